// File: rtl/maj_vote_pkg.sv
// maj_vote_pkg: shared state type and constants for the majority vote controller
package maj_vote_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, HOLD} state_t;
  localparam int NUM_VOTERS = 5;
  localparam int ID_W = 3;
  localparam int MAJ_THRESHOLD = 3;
endpackage

// File: rtl/maj5_eval.sv
// maj5_eval: popcount of recorded yes-votes and the resulting majority bit
module maj5_eval import maj_vote_pkg::*; (
  input  logic [NUM_VOTERS-1:0] votes,
  input  logic [NUM_VOTERS-1:0] mask,
  output logic [2:0]            yes_count,
  output logic                  majority
);
  logic [NUM_VOTERS-1:0] yes;
  always_comb begin
    yes = votes & mask;
    yes_count = '0;
    for (int i = 0; i < NUM_VOTERS; i++) yes_count = yes_count + 3'(yes[i]);
    majority = yes_count >= 3'(MAJ_THRESHOLD);
  end
endmodule

// File: rtl/majority_vote_ctrl.sv
// majority_vote_ctrl: 5-voter ballot collection and majority decision; MAJ_VOTE_TIMEOUT_EN adds a round timeout
module majority_vote_ctrl import maj_vote_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  output logic            busy_o,
  input  logic            ballot_valid_i,
  input  logic [ID_W-1:0] ballot_id_i,
  input  logic            ballot_val_i,
  output logic            ballot_ready_o,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic            result_o,
  output logic [2:0]      yes_count_o,
  output logic [4:0]      rcvd_mask_o,
  output logic            timed_out_o
);
  state_t state, state_nxt;
  logic [NUM_VOTERS-1:0] mask, mask_nxt, votes, votes_nxt, sel, hit;
  logic enter, timeout, eval_maj;
  logic [2:0] eval_yes;
  maj5_eval u_eval (
    .votes(votes),
    .mask(mask),
    .yes_count(eval_yes),
    .majority(eval_maj)
  );
  assign busy_o = state != IDLE;
  assign ballot_ready_o = state == COLLECT;
  assign result_valid_o = state == HOLD;
  assign rcvd_mask_o = mask;
  always_comb begin
    sel = (ballot_id_i != '0 && ballot_id_i <= ID_W'(NUM_VOTERS)) ? NUM_VOTERS'(1) << (ballot_id_i - 1'b1) : '0;
    hit = sel & ~mask & {NUM_VOTERS{ballot_valid_i & ballot_ready_o}};
    mask_nxt = mask | hit;
    votes_nxt = votes | (hit & {NUM_VOTERS{ballot_val_i}});
    enter = state == IDLE && start_i && !abort_i;
    state_nxt = state;
    if (abort_i) state_nxt = IDLE;
    else if (state == IDLE) state_nxt = start_i ? COLLECT : IDLE;
    else if (state == COLLECT) state_nxt = (&mask_nxt || timeout) ? EVAL : COLLECT;
    else if (state == EVAL) state_nxt = HOLD;
    else state_nxt = result_ready_i ? IDLE : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mask <= '0;
      votes <= '0;
      result_o <= 1'b0;
      yes_count_o <= '0;
    end else begin
      state <= state_nxt;
      mask <= (abort_i || enter) ? '0 : mask_nxt;
      votes <= enter ? '0 : votes_nxt;
      if (state == EVAL && !abort_i) begin
        result_o <= eval_maj;
        yes_count_o <= eval_yes;
      end
    end
`ifdef MAJ_VOTE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      timed_out_o <= 1'b0;
    end else begin
      cnt <= enter ? '0 : state == COLLECT ? cnt + CNT_W'(1) : cnt;
      timed_out_o <= enter ? 1'b0 : (state == EVAL && !abort_i) ? ~&mask : timed_out_o;
    end
`else
  assign timeout = 1'b0;
  assign timed_out_o = 1'b0;
`endif
endmodule

// File: tb/tb_majority_vote_ctrl.sv
// tb_majority_vote_ctrl: randomized scoreboard bench for majority_vote_ctrl
module tb_majority_vote_ctrl;
  localparam int T = 16;
`ifdef MAJ_VOTE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct {
    bit       res;
    int       yes;
    bit [4:0] mask;
    bit       to;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, start_i, abort_i, busy_o, ballot_valid_i, ballot_val_i, ballot_ready_o;
  logic result_valid_o, result_ready_i, result_o, timed_out_o;
  logic [2:0] ballot_id_i, yes_count_o;
  logic [4:0] rcvd_mask_o;
  exp_t q[$];
  exp_t cur;
  int s_id[$];
  bit s_val[$];
  int n_cmp = 0, n_err = 0;
  bit last_res;
  int last_yes;
  always #5 clk = ~clk;
  majority_vote_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .abort_i(abort_i),
    .busy_o(busy_o),
    .ballot_valid_i(ballot_valid_i),
    .ballot_id_i(ballot_id_i),
    .ballot_val_i(ballot_val_i),
    .ballot_ready_o(ballot_ready_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_o(result_o),
    .yes_count_o(yes_count_o),
    .rcvd_mask_o(rcvd_mask_o),
    .timed_out_o(timed_out_o)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic add(input int id, input bit v);
    s_id.push_back(id);
    s_val.push_back(v);
  endtask
  task automatic gen_random(input bit partial);
    int ids[5];
    int j, t, k;
    s_id.delete();
    s_val.delete();
    for (int i = 0; i < 5; i++) ids[i] = i + 1;
    for (int i = 4; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = ids[i];
      ids[i] = ids[j];
      ids[j] = t;
    end
    k = partial ? $urandom_range(0, 4) : 5;
    for (int i = 0; i < k; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        t = $urandom_range(0, 2);
        if (t == 0) add(-1, 1'b0);
        else if (t == 1 && i > 0) add(ids[$urandom_range(0, i - 1)], 1'($urandom_range(0, 1)));
        else add(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(6, 7), 1'($urandom_range(0, 1)));
      end
      add(ids[i], 1'($urandom_range(0, 1)));
    end
  endtask
  task automatic run_round(input int hold, input bit pulse, input bit early);
    exp_t e;
    int close, n, lim;
    bit done;
    e.mask = '0;
    e.yes = 0;
    close = 0;
    lim = TO_EN ? T : s_id.size();
    for (int c = 1; close == 0 && c <= lim; c++) begin
      if (c <= s_id.size() && s_id[c-1] >= 1 && s_id[c-1] <= 5 && !e.mask[s_id[c-1]-1]) begin
        e.mask[s_id[c-1]-1] = 1'b1;
        e.yes += int'(s_val[c-1]);
      end
      if (e.mask == 5'h1f || (TO_EN && c == T)) close = c;
    end
    if (close == 0) close = lim;
    e.res = e.yes >= 3;
    e.to = TO_EN && e.mask != 5'h1f;
    q.push_back(e);
    last_res = e.res;
    last_yes = e.yes;
    @(posedge clk); #1;
    start_i = 1'b1;
    result_ready_i = early;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    done = 1'b0;
    for (int c = 1; c <= 300 && !done; c++) begin
      ballot_valid_i = c <= s_id.size() && s_id[c-1] >= 0;
      ballot_id_i = (c <= s_id.size() && s_id[c-1] > 0) ? 3'(s_id[c-1]) : 3'd0;
      ballot_val_i = c <= s_id.size() ? s_val[c-1] : 1'b0;
      @(posedge clk); #1;
      n++;
      done = result_valid_o;
    end
    ballot_valid_i = 1'b0;
    chk("result_arrived", int'(done), 1);
    chk("latency", n, close + 2);
    if (!early)
      for (int i = 0; i < hold; i++) begin
        start_i = pulse && (i % 2 == 0);
        @(posedge clk); #1;
      end
    result_ready_i = 1'b1;
    start_i = pulse;
    @(posedge clk); #1;
    result_ready_i = 1'b0;
    start_i = 1'b0;
    chk("valid_after_accept", int'(result_valid_o), 0);
    chk("busy_after_accept", int'(busy_o), 0);
  endtask
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (result_valid_o && !prev) begin
          chk("queue_nonempty", int'(q.size() > 0), 1);
          if (q.size() > 0) cur = q.pop_front();
        end
        if (result_valid_o) begin
          chk("result", int'(result_o), int'(cur.res));
          chk("yes_count", int'(yes_count_o), cur.yes);
          chk("mask", int'(rcvd_mask_o), int'(cur.mask));
          chk("timed_out", int'(timed_out_o), int'(cur.to));
        end
        prev = result_valid_o;
      end
    end
  end
  initial begin
    rst_n = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    ballot_valid_i = 1'b0;
    ballot_id_i = '0;
    ballot_val_i = 1'b0;
    result_ready_i = 1'b0;
    last_res = 1'b0;
    last_yes = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_valid", int'(result_valid_o), 0);
    chk("rst_result", int'(result_o), 0);
    chk("rst_yes", int'(yes_count_o), 0);
    chk("rst_mask", int'(rcvd_mask_o), 0);
    chk("rst_to", int'(timed_out_o), 0);
    chk("rst_ready", int'(ballot_ready_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy_o), 0);
    s_id = '{1, 2, 3, 4, 5};
    s_val = '{1, 1, 0, 1, 0};
    run_round(0, 1'b0, 1'b0);
    s_id = '{1, 2, 3, 3, 7, 4, 5};
    s_val = '{1, 1, 0, 1, 1, 0, 0};
    run_round(2, 1'b0, 1'b0);
`ifdef MAJ_VOTE_TIMEOUT_EN
    s_id = '{1, 2};
    s_val = '{1, 1};
    run_round(1, 1'b0, 1'b0);
    s_id.delete();
    s_val.delete();
    for (int i = 1; i <= 4; i++) add(i, 1'b1);
    for (int i = 0; i < 11; i++) add(-1, 1'b0);
    add(5, 1'b1);
    run_round(0, 1'b0, 1'b0);
`endif
    gen_random(1'b0);
    run_round(10, 1'b1, 1'b0);
    gen_random(1'b0);
    run_round(0, 1'b0, 1'b1);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    ballot_valid_i = 1'b1;
    ballot_id_i = 3'd1;
    ballot_val_i = 1'b1;
    @(posedge clk); #1;
    ballot_id_i = 3'd2;
    @(posedge clk); #1;
    ballot_valid_i = 1'b0;
    chk("abort_pre_busy", int'(busy_o), 1);
    chk("abort_pre_mask", int'(rcvd_mask_o), 3);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_mask", int'(rcvd_mask_o), 0);
    chk("abort_result_kept", int'(result_o), int'(last_res));
    chk("abort_yes_kept", int'(yes_count_o), last_yes);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_valid", int'(result_valid_o), 0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    ballot_valid_i = 1'b1;
    ballot_id_i = 3'd3;
    ballot_val_i = 1'b1;
    @(posedge clk); #1;
    ballot_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_mask", int'(rcvd_mask_o), 0);
    chk("arst_result", int'(result_o), 0);
    chk("arst_yes", int'(yes_count_o), 0);
    chk("arst_valid", int'(result_valid_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_res = 1'b0;
    last_yes = 0;
    for (int r = 0; r < 40; r++) begin
      gen_random(TO_EN && $urandom_range(0, 2) == 0);
      run_round($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/majority_vote_ctrl.md
# majority_vote_ctrl

Sequencing controller for one 5-voter majority decision. It opens a voting round on `start_i` and collects single-bit ballots from up to five voters over a valid/ready port. It closes the round when all ballots are in, or optionally on timeout, then evaluates the majority and presents the result through a valid/ready output handshake. It sits between voter agents and downstream consumers and owns the single majority evaluator.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum number of COLLECT cycles per round; legal range 2..255.
- `CNT_W`, default `$clog2(TIMEOUT_CYCLES)`: width of the timeout counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start_i` in 1: opens a round; sampled only in IDLE.
- `abort_i` in 1: returns to IDLE from any state; no result is produced.
- `busy_o` out 1: high in every state except IDLE.
- `ballot_valid_i` in 1: ballot present.
- `ballot_id_i` in 3: voter index; legal values 1..5.
- `ballot_val_i` in 1: vote value.
- `ballot_ready_o` out 1: high only in COLLECT.
- `result_valid_o` out 1: result available (HOLD state).
- `result_ready_i` in 1: consumer accepts the result.
- `result_o` out 1: majority decision.
- `yes_count_o` out 3: number of 1-votes counted, 0..5.
- `rcvd_mask_o` out 5: bit k-1 set when voter k's ballot has been recorded.
- `timed_out_o` out 1: round closed by timeout with at least one ballot missing.

## Operation
- States: IDLE, COLLECT, EVAL, HOLD.
  - IDLE→COLLECT on `start_i`.
  - COLLECT→EVAL when the mask is full, or on timeout.
  - EVAL→HOLD unconditionally.
  - HOLD→IDLE on `result_ready_i`.
- Entering COLLECT clears the mask, the vote register, the timeout counter and `timed_out_o`.
- A ballot is accepted on `ballot_valid_i & ballot_ready_o`.
  - Legal id, bit not yet set: the bit is set and the value is stored.
  - Duplicate id: accepted and dropped. First ballot wins.
  - Id 0, 6 or 7: accepted and dropped.
- Missing ballots count as 0.
- EVAL registers `result_o`, `yes_count_o` and `timed_out_o`. `result_o` is 1 when `yes_count_o >= 3`.
- Outputs hold stable in HOLD and keep their last values in IDLE until the next EVAL.
- `abort_i` has priority over every other transition. It clears the mask and leaves `result_o`/`yes_count_o` unchanged.
- `start_i` outside IDLE is ignored.
- Reset values: state IDLE, all outputs 0, mask 0, counter 0.

## Timing
- Cycle 0: `start_i` high in IDLE.
- Cycle 1: COLLECT, `ballot_ready_o` = 1.
- Fastest round: ballots accepted in cycles 1..5, EVAL in cycle 6, `result_valid_o` first high in cycle 7.
- Start-to-result latency is 7 cycles minimum.
- The timeout counter increments each COLLECT cycle. The round closes when the counter reaches `TIMEOUT_CYCLES-1` with the mask not full. EVAL follows in the next cycle.
- Simultaneous final ballot and timeout: the ballot is counted. If the mask becomes full, `timed_out_o` = 0.
- `result_valid_o` must not drop before `result_ready_i`. With `result_ready_i` already high, HOLD lasts exactly one cycle.
- `start_i` on the cycle HOLD exits is ignored. The earliest new start is the first IDLE cycle.
- Asynchronous reset mid-round: immediate return to reset values. No partial result.

## Configuration
- `MAJ_VOTE_TIMEOUT_EN` defined: timeout counter, `timed_out_o` and the COLLECT→EVAL timeout transition are present.
- Not defined: COLLECT exits only on a full mask (or `abort_i`), `timed_out_o` is tied to 0, and no counter is built.

## Structure
- Package `maj_vote_pkg` holds:
  - the state enum type;
  - `NUM_VOTERS = 5`;
  - `ID_W = 3`;
  - `MAJ_THRESHOLD = 3`.
- Sub-module `maj5_eval`: combinational; takes a 5-bit vote vector and a 5-bit mask; outputs the 3-bit popcount of `votes & mask` and the majority bit. It is instantiated once in the controller.

## Test plan
- Start, then ballots ids 1..5 with values 1,1,0,1,0 in consecutive cycles → `result_valid_o` in cycle 7, `result_o` = 1, `yes_count_o` = 3, `timed_out_o` = 0.
- Ballots 1..5 with values 1,1,0,0,0 plus a duplicate id 3 with value 1 and an id 7 ballot → `result_o` = 0, `yes_count_o` = 2, mask 5'b11111.
- Timeout enabled, `TIMEOUT_CYCLES` = 16, only ids 1,2 voting 1 → EVAL after 16 COLLECT cycles, `result_o` = 0, `yes_count_o` = 2, `timed_out_o` = 1, mask 5'b00011.
- Fifth ballot arrives on the final timeout cycle → counted, `timed_out_o` = 0.
- `result_ready_i` held low for 10 cycles → `result_valid_o` and `result_o` stable throughout. `start_i` pulses during HOLD are ignored.
- `abort_i` mid-COLLECT and `rst_n` asserted mid-COLLECT → IDLE next cycle / immediately, `busy_o` = 0, no `result_valid_o`.
